// File: rtl/axis_rr_arbiter_pkg.sv
// Shared types and elaboration helpers for the packet-aware AXI-Stream round-robin arbiter.
package axis_rr_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_t;

  // Source-index width; a single source still needs one bit to hold an index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Beat counter only has to reach MAX_BEATS-1, so 0 (unlimited) collapses to one idle bit.
  function automatic int cnt_width(input int max_beats);
    return (max_beats > 0) ? $clog2(max_beats + 1) : 1;
  endfunction

endpackage

// File: rtl/axis_rr_arbiter_rr_pick.sv
// Rotating-priority selector: first asserted request after 'last', wrapping modulo N.
// Purely combinational; 'any' is low when no request is present.
module rr_pick
  import axis_rr_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    // Offsets 1..N: the previous winner is considered last.
    for (int k = 1; k <= N; k++) begin
      if (!any && req[(int'(last) + k) % N]) begin
        any     = 1'b1;
        gnt_idx = IW'((int'(last) + k) % N);
      end
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-aware round-robin merge of NREQ AXI-Stream sources into one registered stream.
// Latency 1 cycle in->out plus one arbitration bubble per packet; in_tready follows the output register's space.
module axis_rr_arbiter
  import axis_rr_arbiter_pkg::*;
#(
  parameter int  DW        = 128,
  parameter int  NREQ      = 4,
  parameter int  MAX_BEATS = 0,
  localparam int IW        = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_enable,
  input  logic [NREQ*DW-1:0] in_tdata,
  input  logic [NREQ-1:0]   in_tvalid,
  input  logic [NREQ-1:0]   in_tlast,
  output logic [NREQ-1:0]   in_tready,
  output logic [DW-1:0]     out_tdata,
  output logic              out_tlast,
  output logic [IW-1:0]     out_tid,
  output logic              out_tvalid,
  input  logic              out_tready,
  output logic              busy
);

  localparam int BCW = cnt_width(MAX_BEATS);
  localparam logic [BCW-1:0] LIMIT_CNT = BCW'((MAX_BEATS > 0) ? MAX_BEATS - 1 : 0);

  arb_state_t     state, state_nxt;
  logic [IW-1:0]  grant, grant_nxt;
  logic [IW-1:0]  last_grant, last_grant_nxt;
  logic [BCW-1:0] beat_cnt, beat_cnt_nxt;

  logic [IW-1:0]  pick_idx;
  logic           pick_any;
  logic [DW-1:0]  sel_dat;
  logic           sel_vld;
  logic           sel_last;
  logic           xfer_rdy;
  logic           accept;
  logic           at_limit;

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .req     (in_tvalid),
    .last    (last_grant),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // Granted source's lanes, selected by compare rather than a variable part-select.
  always_comb begin
    sel_dat  = '0;
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IW'(i)) begin
        sel_dat  = in_tdata[i*DW +: DW];
        sel_vld  = in_tvalid[i];
        sel_last = in_tlast[i];
      end
    end
  end

  // Ready is derived from state and the output register only, never from in_tvalid.
  assign xfer_rdy = (state == ST_XFER) && (!out_tvalid || out_tready);
  assign accept   = xfer_rdy && sel_vld;
  assign at_limit = (MAX_BEATS != 0) && (beat_cnt == LIMIT_CNT);
  assign busy     = (state == ST_XFER);

  always_comb begin
    in_tready = '0;
    if (xfer_rdy) in_tready[grant] = 1'b1;
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    beat_cnt_nxt   = beat_cnt;
    case (state)
      ST_IDLE: begin
        if (cfg_enable && pick_any) begin
          grant_nxt = pick_idx;
          state_nxt = ST_XFER;
        end
      end
      ST_XFER: begin
        if (accept) begin
          if (sel_last || at_limit) begin
            last_grant_nxt = grant;
            beat_cnt_nxt   = '0;
            state_nxt      = ST_IDLE;
          end else if (MAX_BEATS != 0) begin
            beat_cnt_nxt = beat_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= IW'(NREQ - 1);
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

  // Output register: a new beat may load in the same cycle the previous one drains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_tvalid <= 1'b0;
      out_tdata  <= '0;
      out_tlast  <= 1'b0;
      out_tid    <= '0;
    end else if (accept) begin
      out_tvalid <= 1'b1;
      out_tdata  <= sel_dat;
      out_tlast  <= sel_last || at_limit;
      out_tid    <= grant;
    end else if (out_tvalid && out_tready) begin
      out_tvalid <= 1'b0;
    end
  end

endmodule
